// File: rtl/i2c_regfile_slave.sv
// I2C target emulating a DS1307-style register file: 7-bit device address,
// DEPTH-byte memory, auto-incrementing pointer that wraps, local read port
// and a write-event strobe for surrounding logic.
module i2c_regfile_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter int         DEPTH    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scl,
  inout  wire                        sda,
  input  logic [$clog2(DEPTH)-1:0]   host_addr,
  output logic [7:0]                 host_rdata,
  output logic                       wr_stb,
  output logic [$clog2(DEPTH)-1:0]   wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   ptr;
  logic [AW-1:0]   ptr_nxt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shift;
  logic            rw;
  logic            sda_oe;

  logic            scl_p0, scl_p1, scl_p2;
  logic            sda_p0, sda_p1, sda_p2;
  logic            scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]      byte_in;
  logic            mem_we;

  // Open-drain output: only ever pull low or release.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_p0, scl_p1, scl_p2} <= 3'b111;
      {sda_p0, sda_p1, sda_p2} <= 3'b111;
    end else begin
      scl_p0 <= scl;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign byte_in   = {shift[6:0], sda_p1};
  assign ptr_nxt   = ptr + AW'(1);
  assign mem_we    = scl_rise && (state == WDATA) && (bit_cnt == 4'd7);

  // Register file storage, written on the last data bit of a write byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[ptr] <= byte_in;
    end
  end

  // Local read port; a same-cycle I2C write is visible one cycle later.
  always_ff @(posedge clk) begin
    if (rst) host_rdata <= 8'h00;
    else     host_rdata <= mem[host_addr];
  end

  // Protocol FSM: START/STOP first, then bit sampling on rise, sda updates on fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      bit_cnt <= 4'd0;
      shift   <= 8'h00;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'h00;
    end else begin
      wr_stb <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (scl_rise) begin
        shift   <= byte_in;
        bit_cnt <= bit_cnt + 4'd1;
        case (state)
          ADDR: begin
            if (bit_cnt == 4'd7) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                rw    <= byte_in[0];
                state <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            bit_cnt <= 4'd0;
            if (rw) begin
              shift <= mem[ptr];
              state <= RDATA;
            end else begin
              state <= PTR;
            end
          end
          PTR: begin
            if (bit_cnt == 4'd7) begin
              ptr   <= byte_in[AW-1:0];
              state <= PTR_ACK;
            end
          end
          PTR_ACK: begin
            bit_cnt <= 4'd0;
            state   <= WDATA;
          end
          WDATA: begin
            if (bit_cnt == 4'd7) begin
              wr_stb  <= 1'b1;
              wr_addr <= ptr;
              wr_data <= byte_in;
              ptr     <= ptr_nxt;
              state   <= WDATA_ACK;
            end
          end
          WDATA_ACK: begin
            bit_cnt <= 4'd0;
            state   <= WDATA;
          end
          RACK: begin
            bit_cnt <= 4'd0;
            if (!sda_p1) begin
              ptr   <= ptr_nxt;
              shift <= mem[ptr_nxt];
              state <= RDATA;
            end else begin
              state <= IGNORE;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK, PTR_ACK, WDATA_ACK: sda_oe <= 1'b1;
          RDATA: begin
            if (bit_cnt == 4'd8) begin
              sda_oe <= 1'b0;
              state  <= RACK;
            end else begin
              sda_oe <= ~shift[7];
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_regfile_slave.sv
// Bench for i2c_regfile_slave: bit-banged I2C master, array-based model of
// the register file and pointer, directed scenarios plus random transactions.
module tb_i2c_regfile_slave;

  localparam int         Q     = 6;      // clk cycles per quarter scl period
  localparam logic [7:0] WADDR = 8'hD0;
  localparam logic [7:0] RADDR = 8'hD1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  logic [5:0] host_addr = 6'd0;
  logic [7:0] host_rdata;
  logic       wr_stb;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  wire        sda;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_mem [64];
  logic [5:0] ref_ptr;
  logic [7:0] wbuf [$];
  logic [13:0] wr_log [$];
  int         slave_low = 0;
  logic       coll_arm = 1'b0;
  int         coll_phase = 0;
  logic [7:0] coll_old = 8'h00;
  logic [7:0] coll_new = 8'h00;

  i2c_regfile_slave #(.DEV_ADDR(7'h68), .DEPTH(64)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .host_addr(host_addr), .host_rdata(host_rdata),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Log every write event reported on the local port.
  always @(negedge clk) if (wr_stb) wr_log.push_back({wr_addr, wr_data});

  // Count cycles where the slave pulls sda low.
  always @(posedge clk) if (!m_oe && sda === 1'b0) slave_low <= slave_low + 1;

  // Capture host_rdata in the write cycle to address 5 and the cycle after.
  always @(negedge clk) begin
    if (coll_phase == 1) begin
      coll_new   <= host_rdata;
      coll_phase <= 2;
    end else if (coll_arm && coll_phase == 0 && wr_stb && wr_addr == 6'd5) begin
      coll_old   <= host_rdata;
      coll_phase <= 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    m_oe = ~b;
    clks(Q);
    scl = 1'b1;
    clks(2 * Q);
    r = sda;
    scl = 1'b0;
    clks(Q);
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; clks(Q);
    scl  = 1'b1; clks(Q);
    m_oe = 1'b1; clks(Q);
    scl  = 1'b0; clks(Q);
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; clks(Q);
    scl  = 1'b1; clks(Q);
    m_oe = 1'b0; clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic recv_byte(input logic ack_it, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(~ack_it, r);
  endtask

  // Write transaction: pointer byte then wbuf contents; model updates mem/ptr.
  task automatic do_write(input logic [7:0] p, input string tag);
    logic       ack;
    int         acks;
    int         base;
    logic [5:0] exp_a [$];
    logic [7:0] exp_d [$];
    base = wr_log.size();
    acks = 0;
    i2c_start();
    check_eq({tag, "_busy_hi"}, 32'(busy), 32'd1);
    send_byte(WADDR, ack); acks += int'(ack);
    send_byte(p, ack);     acks += int'(ack);
    ref_ptr = 6'(int'(p) % 64);
    foreach (wbuf[i]) begin
      send_byte(wbuf[i], ack);
      acks += int'(ack);
      exp_a.push_back(ref_ptr);
      exp_d.push_back(wbuf[i]);
      ref_mem[ref_ptr] = wbuf[i];
      ref_ptr = 6'((int'(ref_ptr) + 1) % 64);
    end
    i2c_stop();
    clks(2);
    check_eq({tag, "_busy_lo"}, 32'(busy), 32'd0);
    check_eq({tag, "_acks"}, 32'(acks), 32'(wbuf.size() + 2));
    check_eq({tag, "_nstb"}, 32'(wr_log.size() - base), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && base + i < wr_log.size(); i++) begin
      check_eq($sformatf("%s_waddr%0d", tag, i), 32'(wr_log[base+i][13:8]), 32'(exp_a[i]));
      check_eq($sformatf("%s_wdata%0d", tag, i), 32'(wr_log[base+i][7:0]), 32'(exp_d[i]));
    end
  endtask

  // Read transaction, optionally preceded by a pointer set and repeated START.
  task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n, input string tag);
    logic       ack;
    int         acks;
    logic [7:0] d;
    acks = 0;
    i2c_start();
    if (set_ptr) begin
      send_byte(WADDR, ack); acks += int'(ack);
      send_byte(p, ack);     acks += int'(ack);
      ref_ptr = 6'(int'(p) % 64);
      i2c_start();
    end
    send_byte(RADDR, ack); acks += int'(ack);
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, d);
      check_eq($sformatf("%s_rd%0d", tag, i), 32'(d), 32'(ref_mem[ref_ptr]));
      if (i < n - 1) ref_ptr = 6'((int'(ref_ptr) + 1) % 64);
    end
    clks(2);
    check_eq({tag, "_sda_rel"}, 32'(sda), 32'd1);
    i2c_stop();
    clks(2);
    check_eq({tag, "_busy_lo"}, 32'(busy), 32'd0);
    check_eq({tag, "_acks"}, 32'(acks), set_ptr ? 32'd3 : 32'd1);
  endtask

  task automatic scan_mem(input string tag);
    for (int a = 0; a < 64; a++) begin
      host_addr = 6'(a);
      clks(1);
      check_eq($sformatf("%s_mem%0d", tag, a), 32'(host_rdata), 32'(ref_mem[a]));
    end
  endtask

  initial begin
    logic       ack;
    logic       r;
    int         low0;
    int         wr0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    ref_ptr = 6'd0;

    // Reset state
    clks(4);
    rst = 1'b0;
    clks(1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wr_stb", 32'(wr_stb), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    check_eq("rst_host_rdata", 32'(host_rdata), 32'd0);
    check_eq("rst_sda", 32'(sda), 32'd1);

    // Write burst 01..05 at pointer 8
    wbuf = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    do_write(8'h08, "burst");
    host_addr = 6'd10;
    clks(1);
    check_eq("host_rd10", 32'(host_rdata), 32'h03);

    // Pointer read of the same five bytes
    do_read(1'b1, 8'h08, 5, "ptrrd");

    // Wrap at the top of the register file
    wbuf = '{8'hAA, 8'hBB, 8'hCC};
    do_write(8'h3E, "wrap");
    do_read(1'b1, 8'h3F, 2, "wraprd");
    scan_mem("wrap");

    // Address mismatch: no ACK, no drive, no write
    low0 = slave_low;
    wr0  = wr_log.size();
    i2c_start();
    send_byte(8'hA0, ack);
    check_eq("mis_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h55, ack);
    check_eq("mis_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    clks(2);
    check_eq("mis_sda_low", 32'(slave_low - low0), 32'd0);
    check_eq("mis_wr_stb", 32'(wr_log.size() - wr0), 32'd0);
    scan_mem("mis");

    // Collision between I2C write and local read of address 5
    wbuf = '{8'h3C};
    do_write(8'h05, "coll_pre");
    host_addr = 6'd5;
    coll_arm = 1'b1;
    wbuf = '{8'h77};
    do_write(8'h05, "coll");
    coll_arm = 1'b0;
    check_eq("coll_seen", 32'(coll_phase), 32'd2);
    check_eq("coll_old", 32'(coll_old), 32'h3C);
    check_eq("coll_new", 32'(coll_new), 32'h77);

    // Random transactions against the model
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        wbuf.delete();
        repeat ($urandom_range(1, 5)) wbuf.push_back(8'($urandom));
        do_write(8'($urandom_range(0, 255)), $sformatf("rnd_w%0d", t));
      end else begin
        do_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                $urandom_range(1, 5), $sformatf("rnd_r%0d", t));
      end
    end
    scan_mem("rnd");

    // Reset during bit 4 of a read byte whose upper nibble is zero
    wbuf = '{8'h0F};
    do_write(8'h20, "rst_pre");
    i2c_start();
    send_byte(WADDR, ack);
    send_byte(8'h20, ack);
    i2c_start();
    send_byte(RADDR, ack);
    check_eq("rstmid_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, r);
    check_eq("rstmid_drive", 32'(sda), 32'd0);
    check_eq("rstmid_busy_hi", 32'(busy), 32'd1);
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    check_eq("rstmid_sda", 32'(sda), 32'd1);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_hrd", 32'(host_rdata), 32'd0);
    i2c_stop();
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    ref_ptr = 6'd0;
    scan_mem("rstmid");
    wbuf = '{8'h5A, 8'hA5, 8'h3C};
    do_write(8'h11, "post_rst");
    do_read(1'b1, 8'h11, 3, "post_rst_rd");
    scan_mem("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_regfile_slave.md
# i2c_regfile_slave

I2C target (responder) emulating a DS1307-style device: 7-bit device address, 64-byte register file, auto-incrementing register pointer with wrap. It sits on the same `scl`/`sda` bus as the existing I2C master and is the on-chip counterpart used to exercise that master's write, set-pointer and read transactions without an external chip. A local port exposes register contents and write events to surrounding logic.

## Interface
- `DEV_ADDR`, 7'h68: 7-bit device address; wire byte 8'hD0 for write, 8'hD1 for read.
- `DEPTH`, 64: register count; power of two; pointer width is log2(`DEPTH`).
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `scl` input 1: I2C clock from the master; asynchronous to `clk`.
- `sda` inout 1: I2C data; open-drain, driven only `1'b0` or `1'bz`.
- `host_addr` input 6: local read address.
- `host_rdata` output 8: `mem[host_addr]`, registered.
- `wr_stb` output 1: one-cycle pulse when a register is written over I2C.
- `wr_addr` output 6: address of that write; valid with `wr_stb`.
- `wr_data` output 8: data of that write; valid with `wr_stb`.
- `busy` output 1: high from START to STOP.

## Operation
- `scl` and `sda` each pass through a 2-flop synchronizer. `scl` rise and fall are detected on the synchronized value.
- START is `sda` falling while `scl` is high. STOP is `sda` rising while `scl` is high. Both are detected in every state and take priority over bit processing.
- Data is sampled on `scl` rise. `sda` output changes only on `scl` fall.
- States:
  - `IDLE`: wait for START.
  - `ADDR`: shift 8 bits.
    - Upper 7 bits == `DEV_ADDR`: go to `ADDR_ACK`.
    - Otherwise: go to `IGNORE`, with `sda` released until the next START or STOP.
  - `ADDR_ACK`: drive `sda` low for the 9th clock.
    - R/W = 0: go to `PTR`.
    - R/W = 1: load shift register from `mem[ptr]` and go to `RDATA`.
  - `PTR`: shift 8 bits; `ptr <= byte[5:0]` (bits 7:6 ignored). Go to `PTR_ACK`, which ACKs and then goes to `WDATA`.
  - `WDATA`: shift 8 bits. On the 8th rise: `mem[ptr] <= byte`, pulse `wr_stb`, `ptr <= ptr+1` mod `DEPTH`. Go to `WDATA_ACK`, which ACKs and returns to `WDATA`.
  - `RDATA`: drive the shift register MSB-first, with `sda` released for 1-bits. After 8 bits, release `sda` and go to `RACK`.
  - `RACK`: sample the master's bit on the 9th rise.
    - ACK (0): `ptr <= ptr+1`, load `mem[ptr+1]`, go to `RDATA`.
    - NACK (1): go to `IGNORE`.
- Repeated START from any state: go to `ADDR`, release `sda`, keep `ptr`. This implements the set-pointer-then-read sequence.
- STOP from any state: go to `IDLE`, release `sda`, `busy` <= 0, keep `ptr`.
- Pointer wrap: address 63 increments to 0, for both reads and writes.
- No clock stretching. Slave ACK is never withheld for a matching address or for data bytes.

## Timing
- `clk` frequency is at least 16× `scl` frequency.
- Reset values:
  - state `IDLE`, `ptr` 0, all `mem` 8'h00.
  - `sda` released.
  - `wr_stb` 0, `wr_addr` 0, `wr_data` 0, `busy` 0, `host_rdata` 0.
- `rst` mid-transfer: next cycle the block is in the reset state with `sda` released. The bus transfer in progress is then ignored until a fresh START.
- `sda` ACK drive and data bit changes: applied 3 `clk` after the physical `scl` fall (2 sync + 1 register). `sda` is held through the following `scl` high period and released on the next detected fall.
- `wr_stb`, `wr_addr`, `wr_data`: asserted the cycle after the 8th data-bit rise is detected; `wr_stb` lasts exactly 1 cycle.
- `host_rdata`: 1-cycle latency from `host_addr`. If an I2C write hits the same address in the same cycle, `host_rdata` returns the old value and the new value appears on the next cycle.
- `busy`: rises the cycle after START is detected; falls the cycle after STOP is detected.

## Test plan
- Write burst: START, D0, 08, 01..05, STOP.
  - Expect 7 ACKs.
  - Expect `wr_stb` ×5 with `wr_addr` 8..12 and `wr_data` 01..05.
  - `host_addr`=10 then gives `host_rdata`=03.
- Pointer read: START, D0, 08, repeated START, D1, then read 5 bytes with ACK ×4 and NACK on the last, STOP.
  - Expect data 01..05.
  - Expect `sda` released after the NACK.
- Wrap: write 0x3E then AA, BB, CC.
  - Expect `mem[62]`=AA, `mem[63]`=BB, `mem[0]`=CC.
  - A read from 0x3F returns BB, then CC.
- Address mismatch: START, A0, 55, STOP.
  - Expect no ACK and no `wr_stb`.
  - Expect `sda` never driven and memory unchanged.
- Reset mid-read: assert `rst` during bit 4 of an RDATA byte.
  - Expect `sda` released the next cycle, `busy`=0, and `mem` cleared to 00.
  - A following full write transaction succeeds.
- Collision: an I2C write of 77 to address 5 in the same cycle `host_addr`=5.
  - Expect `host_rdata` shows the old value, then 77 on the next cycle.
